// File: rtl/pll_reset_sequencer.sv
// rtl/pll_reset_sequencer.sv - PLL reset pulse, lock qualification and core reset release on refclk.
// PLL_AUTO_RELOCK_EN: when defined, a lock loss re-sequences the PLL automatically instead of parking in LOST.
module pll_reset_sequencer #(
  parameter int RST_PULSE_CYC    = 16,
  parameter int LOCK_STABLE_CYC  = 1024,
  parameter int LOCK_TIMEOUT_CYC = 50000,
  parameter int CNT_W            = 20
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       restart_req,
  output logic       pll_rst,
  output logic       core_rst_n,
  output logic       ready,
  output logic [2:0] state_o,
  output logic [7:0] fault_cnt
);

  typedef enum logic [2:0] {
    ST_PULSE  = 3'd0,
    ST_WAIT   = 3'd1,
    ST_STABLE = 3'd2,
    ST_RUN    = 3'd3,
    ST_LOST   = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(RST_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYC - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             fault_inc;
  logic             lk_meta, lk_s;

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    fault_inc = 1'b0;
    case (state)
      ST_PULSE: begin
        if (cnt == PULSE_LAST) begin
          cnt_nx   = '0;
          state_nx = ST_WAIT;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      ST_WAIT: begin
        if (lk_s) begin
          cnt_nx   = '0;
          state_nx = ST_STABLE;
        end else if (cnt == TIMEOUT_LAST) begin
          fault_inc = 1'b1;
          cnt_nx    = '0;
          state_nx  = ST_PULSE;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      ST_STABLE: begin
        // A dropout here is treated as lock still settling, so it is not counted.
        if (!lk_s) begin
          cnt_nx   = '0;
          state_nx = ST_WAIT;
        end else if (cnt == STABLE_LAST) begin
          cnt_nx   = '0;
          state_nx = ST_RUN;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      ST_RUN: begin
        if (!lk_s) begin
          fault_inc = 1'b1;
          state_nx  = ST_LOST;
        end
      end
      ST_LOST: begin
`ifdef PLL_AUTO_RELOCK_EN
        cnt_nx   = '0;
        state_nx = ST_PULSE;
`else
        state_nx = ST_LOST;
`endif
      end
      default: begin
        cnt_nx   = '0;
        state_nx = ST_PULSE;
      end
    endcase

    // Restart overrides the transition but keeps any fault detected this cycle.
    if (restart_req && (state != ST_PULSE)) begin
      cnt_nx   = '0;
      state_nx = ST_PULSE;
    end
  end

  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      lk_meta    <= 1'b0;
      lk_s       <= 1'b0;
      state      <= ST_PULSE;
      cnt        <= '0;
      fault_cnt  <= 8'd0;
      pll_rst    <= 1'b1;
      core_rst_n <= 1'b0;
      ready      <= 1'b0;
    end else begin
      lk_meta    <= pll_locked;
      lk_s       <= lk_meta;
      state      <= state_nx;
      cnt        <= cnt_nx;
      if (fault_inc && (fault_cnt != 8'hFF)) begin
        fault_cnt <= fault_cnt + 8'd1;
      end
      pll_rst    <= (state_nx == ST_PULSE);
      core_rst_n <= (state_nx == ST_RUN);
      ready      <= (state_nx == ST_RUN);
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb/tb_pll_reset_sequencer.sv - Vector-table bench for pll_reset_sequencer with an expected-value queue.
module tb_pll_reset_sequencer;

  logic       refclk = 1'b0;
  logic       rst_n;
  logic       pll_locked;
  logic       restart_req;
  logic       pll_rst;
  logic       core_rst_n;
  logic       ready;
  logic [2:0] state_o;
  logic [7:0] fault_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 refclk = ~refclk;

  pll_reset_sequencer #(
    .RST_PULSE_CYC   (4),
    .LOCK_STABLE_CYC (8),
    .LOCK_TIMEOUT_CYC(32),
    .CNT_W           (20)
  ) dut (
    .refclk     (refclk),
    .rst_n      (rst_n),
    .pll_locked (pll_locked),
    .restart_req(restart_req),
    .pll_rst    (pll_rst),
    .core_rst_n (core_rst_n),
    .ready      (ready),
    .state_o    (state_o),
    .fault_cnt  (fault_cnt)
  );

  typedef struct {
    logic       rst_n;
    logic       locked;
    logic       restart;
    int         cyc;
    logic       pll_rst;
    logic       core_rst_n;
    logic       ready;
    logic [2:0] st;
    logic [7:0] fault;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  task automatic add(input logic r, input logic l, input logic q, input int c,
                     input logic pr, input logic cr, input logic rd,
                     input logic [2:0] s, input logic [7:0] f);
    vec_t v;
    v.rst_n = r; v.locked = l; v.restart = q; v.cyc = c;
    v.pll_rst = pr; v.core_rst_n = cr; v.ready = rd; v.st = s; v.fault = f;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  initial begin
    vec_t v;
    vec_t e;
    rst_n       = 1'b0;
    pll_locked  = 1'b0;
    restart_req = 1'b0;

    //  rst lk rq cyc   prst core rdy st fault
    // Nominal bring-up: pll_rst high 4 cycles, locked at +10, RUN 2+1+8 edges later.
    add(0, 0, 0, 3,    1, 0, 0, 3'd0, 8'd0);
    add(1, 0, 0, 3,    1, 0, 0, 3'd0, 8'd0);
    add(1, 0, 0, 1,    0, 0, 0, 3'd1, 8'd0);
    add(1, 0, 0, 6,    0, 0, 0, 3'd1, 8'd0);
    add(1, 1, 0, 2,    0, 0, 0, 3'd1, 8'd0);
    add(1, 1, 0, 1,    0, 0, 0, 3'd2, 8'd0);
    add(1, 1, 0, 7,    0, 0, 0, 3'd2, 8'd0);
    add(1, 1, 0, 1,    0, 1, 1, 3'd3, 8'd0);
    // One-cycle lock dropout in RUN.
    add(1, 0, 0, 1,    0, 1, 1, 3'd3, 8'd0);
    add(1, 1, 0, 1,    0, 1, 1, 3'd3, 8'd0);
    add(1, 1, 0, 1,    0, 0, 0, 3'd4, 8'd1);
`ifdef PLL_AUTO_RELOCK_EN
    add(1, 1, 0, 1,    1, 0, 0, 3'd0, 8'd1);
`else
    add(1, 1, 0, 20,   0, 0, 0, 3'd4, 8'd1);
    add(1, 1, 1, 1,    1, 0, 0, 3'd0, 8'd1);
`endif
    add(1, 1, 0, 3,    1, 0, 0, 3'd0, 8'd1);
    add(1, 1, 0, 1,    0, 0, 0, 3'd1, 8'd1);
    add(1, 1, 0, 1,    0, 0, 0, 3'd2, 8'd1);
    add(1, 1, 0, 8,    0, 1, 1, 3'd3, 8'd1);
    // Glitch during STABLE restarts the stable count, no fault.
    add(0, 0, 0, 2,    1, 0, 0, 3'd0, 8'd0);
    add(1, 0, 0, 4,    0, 0, 0, 3'd1, 8'd0);
    add(1, 1, 0, 3,    0, 0, 0, 3'd2, 8'd0);
    add(1, 1, 0, 2,    0, 0, 0, 3'd2, 8'd0);
    add(1, 0, 0, 1,    0, 0, 0, 3'd2, 8'd0);
    add(1, 1, 0, 1,    0, 0, 0, 3'd2, 8'd0);
    add(1, 1, 0, 1,    0, 0, 0, 3'd1, 8'd0);
    add(1, 1, 0, 1,    0, 0, 0, 3'd2, 8'd0);
    add(1, 1, 0, 7,    0, 0, 0, 3'd2, 8'd0);
    add(1, 1, 0, 1,    0, 1, 1, 3'd3, 8'd0);
    // Timeouts: 36-cycle loop, one fault per loop.
    add(0, 0, 0, 2,    1, 0, 0, 3'd0, 8'd0);
    add(1, 0, 0, 35,   0, 0, 0, 3'd1, 8'd0);
    add(1, 0, 0, 1,    1, 0, 0, 3'd0, 8'd1);
    add(1, 0, 0, 35,   0, 0, 0, 3'd1, 8'd1);
    add(1, 0, 0, 1,    1, 0, 0, 3'd0, 8'd2);
    add(1, 0, 0, 36,   1, 0, 0, 3'd0, 8'd3);
    // Restart coinciding with lock loss in RUN: PULSE and the fault still counts.
    add(1, 1, 0, 4,    0, 0, 0, 3'd1, 8'd3);
    add(1, 1, 0, 1,    0, 0, 0, 3'd2, 8'd3);
    add(1, 1, 0, 8,    0, 1, 1, 3'd3, 8'd3);
    add(1, 0, 0, 2,    0, 1, 1, 3'd3, 8'd3);
    add(1, 0, 1, 1,    1, 0, 0, 3'd0, 8'd4);
    // Restart mid-PULSE must not stretch the pulse.
    add(1, 0, 0, 1,    1, 0, 0, 3'd0, 8'd4);
    add(1, 0, 1, 1,    1, 0, 0, 3'd0, 8'd4);
    add(1, 0, 0, 1,    1, 0, 0, 3'd0, 8'd4);
    add(1, 0, 0, 1,    0, 0, 0, 3'd1, 8'd4);
    add(1, 0, 1, 1,    1, 0, 0, 3'd0, 8'd4);
    // 260 further timeouts saturate the fault counter.
    add(1, 0, 0, 260 * 36, 1, 0, 0, 3'd0, 8'd255);

    for (int i = 0; i < vecs.size(); i++) begin
      v           = vecs[i];
      rst_n       = v.rst_n;
      pll_locked  = v.locked;
      restart_req = v.restart;
      exp_q.push_back(v);
      repeat (v.cyc) @(posedge refclk);
      #1;
      e = exp_q.pop_front();
      chk($sformatf("v%0d pll_rst", i),    int'(pll_rst),    int'(e.pll_rst));
      chk($sformatf("v%0d core_rst_n", i), int'(core_rst_n), int'(e.core_rst_n));
      chk($sformatf("v%0d ready", i),      int'(ready),      int'(e.ready));
      chk($sformatf("v%0d state_o", i),    int'(state_o),    int'(e.st));
      chk($sformatf("v%0d fault_cnt", i),  int'(fault_cnt),  int'(e.fault));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
